// File: rtl/dma_axi_read_master_if.sv
// AXI4 read address and read data channel bundle used by the DMA read master.
interface dma_axi_read_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
);
   logic [ID_W-1:0]   arid;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/dma_axi_read_master.sv
// One INCR read burst per request; R beats go straight to the FIFO, rready follows ~fifo_full.
// Optional watchdog under `DMA_RD_TIMEOUT_EN aborts a burst after TIMEOUT_CYCLES idle cycles.
module dma_axi_read_master #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int ID_W           = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start_read_burst,
   input  logic [7:0]            i_burst_len,
   input  logic [ADDR_W-1:0]     i_src_addr,
   input  logic [1:0]            i_transfer_width,
   output logic                  o_read_burst_done,
   output logic                  o_axi_error,
   output logic                  o_rd_busy,
   output logic [8:0]            o_beat_count,
   output logic                  o_fifo_wr_en,
   output logic [DATA_W-1:0]     o_fifo_wdata,
   input  logic                  i_fifo_full,
   dma_axi_read_master_if.master m_axi
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_araddr;
   logic [7:0]        r_arlen;
   logic [2:0]        r_arsize;
   logic [8:0]        r_beat_count;
   logic              r_err;
   logic              r_busy;

   logic              w_arvalid;
   logic              w_rready;
   logic              w_ar_hs;
   logic              w_r_hs;
   logic              w_final;
   logic              w_end;
   logic              w_timeout;

   assign w_arvalid = (r_state == S_ADDR);
   assign w_rready  = (r_state == S_DATA) & ~i_fifo_full;
   assign w_ar_hs   = w_arvalid & m_axi.arready;
   assign w_r_hs    = w_rready & m_axi.rvalid;
   assign w_final   = (r_beat_count == {1'b0, r_arlen});
   assign w_end     = w_r_hs & (m_axi.rlast | w_final);

   assign m_axi.arid    = '0;
   assign m_axi.araddr  = r_araddr;
   assign m_axi.arlen   = r_arlen;
   assign m_axi.arsize  = r_arsize;
   assign m_axi.arburst = 2'b01;
   assign m_axi.arvalid = w_arvalid;
   assign m_axi.rready  = w_rready;

   // Accepted beats are forwarded in the same cycle; no skid storage is needed.
   assign o_fifo_wr_en  = w_r_hs;
   assign o_fifo_wdata  = m_axi.rdata;
   assign o_axi_error   = r_err;
   assign o_rd_busy     = r_busy;
   assign o_beat_count  = r_beat_count;

`ifdef DMA_RD_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_idle_cnt;
   logic             w_waiting;

   assign w_waiting = (r_state == S_ADDR) | (r_state == S_DATA);
   assign w_timeout = w_waiting & ~w_ar_hs & ~w_r_hs
                    & (r_idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst || !w_waiting || w_ar_hs || w_r_hs) begin
         r_idle_cnt <= '0;
      end else begin
         r_idle_cnt <= r_idle_cnt + 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_nxt       = r_state;
      o_read_burst_done = 1'b0;
      case (r_state)
         S_IDLE: if (i_start_read_burst) w_state_nxt = S_ADDR;
         S_ADDR: begin
            if (w_ar_hs)        w_state_nxt = S_DATA;
            else if (w_timeout) w_state_nxt = S_DONE;
         end
         S_DATA: if (w_end || w_timeout) w_state_nxt = S_DONE;
         S_DONE: begin
            o_read_burst_done = 1'b1;
            w_state_nxt       = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_araddr     <= '0;
         r_arlen      <= '0;
         r_arsize     <= '0;
         r_beat_count <= '0;
         r_err        <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (i_start_read_burst) begin
                  r_araddr     <= i_src_addr;
                  r_arlen      <= i_burst_len;
                  r_arsize     <= (i_transfer_width == 2'd3) ? 3'b010 : {1'b0, i_transfer_width};
                  r_beat_count <= '0;
                  r_err        <= 1'b0;
                  r_busy       <= 1'b1;
               end
            end
            S_DATA: begin
               if (w_r_hs) begin
                  r_beat_count <= r_beat_count + 9'd1;
                  // Covers both an early rlast and an rlast missing on the final beat.
                  if (m_axi.rresp != 2'b00 || (m_axi.rlast != w_final)) r_err <= 1'b1;
               end
            end
            S_DONE: r_busy <= 1'b0;
            default: ;
         endcase
         if (w_timeout) r_err <= 1'b1;
      end
   end

endmodule

// File: doc/dma_axi_read_master.md
Name: dma_axi_read_master

Overview:
- AXI4 read-channel engine for the DMA.
- Sits between the DMA control FSM and the read-data FIFO.
- On each burst request it issues one INCR burst on AR, accepts R beats, and pushes them into the FIFO under full-backpressure.
- Reports per-burst completion and error back to the control FSM.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI read data / FIFO write data width.
- ID_W, 4, AXI ID width; ARID driven constant 0.
- TIMEOUT_CYCLES, 1024, idle-cycle limit for the watchdog (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start_read_burst  in  1  one-cycle burst request from control FSM
- burst_len  in  8  AXI ARLEN (beats-1), sampled with start_read_burst
- src_addr  in  ADDR_W  burst start address, sampled with start_read_burst
- transfer_width  in  2  0=1B, 1=2B, 2=4B, 3 treated as 4B
- read_burst_done  out  1  one-cycle pulse at burst end
- axi_error  out  1  error status of last burst, valid with read_burst_done
- rd_busy  out  1  high from accepted request until done pulse
- beat_count  out  9  beats accepted in current/last burst
- m_axi_arid  out  ID_W  read ID
- m_axi_araddr  out  ADDR_W  read address
- m_axi_arlen  out  8  burst length
- m_axi_arsize  out  3  beat size
- m_axi_arburst  out  2  burst type, constant 2'b01 INCR
- m_axi_arvalid  out  1  AR valid
- m_axi_arready  in  1  AR ready
- m_axi_rdata  in  DATA_W  read data
- m_axi_rresp  in  2  read response
- m_axi_rlast  in  1  last beat
- m_axi_rvalid  in  1  R valid
- m_axi_rready  out  1  R ready
- fifo_wr_en  out  1  FIFO push strobe
- fifo_wdata  out  DATA_W  FIFO push data
- fifo_full  in  1  FIFO full flag

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - State returns to IDLE.
  - arvalid, rready, fifo_wr_en, read_burst_done, axi_error and rd_busy are 0.
  - beat_count, araddr, arlen and arsize are 0.
  - A reset asserted mid-burst aborts immediately with no done pulse; outstanding AXI beats are the system reset's responsibility.
- State machine: IDLE, ADDR, DATA, DONE.
- IDLE:
  - On start_read_burst, register src_addr, burst_len, and arsize = transfer_width (3 maps to 3'b010).
  - Clear beat_count and the error flag, set rd_busy, and go to ADDR.
  - arvalid asserts the cycle after the request.
- ADDR:
  - arvalid=1 with all AR fields stable until arready.
  - On arvalid & arready, go to DATA.
- DATA:
  - rready = ~fifo_full, combinational.
  - Accepted beat = rvalid & rready. On the same cycle, fifo_wr_en=1 and fifo_wdata=rdata, with no added latency.
  - beat_count increments on each accepted beat.
  - rresp != OKAY (2'b00) on any beat sets the sticky error flag.
  - The burst ends on the accepted beat where rlast=1 or beat_count == arlen.
  - If those two conditions do not coincide (early rlast, or rlast missing on the final beat), set the error flag.
  - On burst end, go to DONE.
- DONE:
  - read_burst_done=1 for exactly one cycle, with axi_error = error flag.
  - Clear rd_busy and return to IDLE.
  - axi_error holds its value until the next accepted request clears it.
- start_read_burst outside IDLE is ignored.
- A request in the same cycle as DONE is ignored; the control FSM never issues it.
- Latency:
  - Request to arvalid: 1 cycle.
  - Last beat to read_burst_done: 1 cycle.
  - Minimum burst of 1 beat with arready/rvalid held high: request at T0, AR handshake at T1, R beat at T2, done at T3.
- Widths:
  - beat_count is 9 bits, so 256 beats do not wrap.
  - Address is not incremented internally; the datapath advances the address.
- fifo_full asserted mid-burst stalls R with no data loss. There is no timeout unless the optional feature is compiled in.

Optional Feature:
- Macro: DMA_RD_TIMEOUT_EN.
- With the macro defined:
  - A counter counts consecutive ADDR/DATA cycles with no AR or R handshake.
  - The counter resets on any handshake.
  - On reaching TIMEOUT_CYCLES, set the error flag, drop arvalid/rready, go to DONE, and pulse read_burst_done with axi_error=1.
- Without the macro: no counter logic, and the block waits indefinitely.

Test Plan:
- Single beat: src_addr=0x1000, burst_len=0, width=2, arready/rvalid always 1, rdata=0xA5A5A5A5, rlast=1. Expect araddr=0x1000, arlen=0, arsize=2, arburst=1; one fifo_wr_en with 0xA5A5A5A5; done at T3 with axi_error=0; beat_count=1.
- 16-beat burst with slave stall: arready delayed 3 cycles, rdata=0..15. Expect exactly 16 FIFO pushes in order, done 1 cycle after beat 15, beat_count=16.
- Backpressure: fifo_full=1 for cycles 5..9 of a 16-beat burst. Expect rready=0 and no fifo_wr_en during 5..9; all 16 values pushed in order, none duplicated or lost.
- Error response: 4-beat burst with rresp=2'b10 on beat 2. Expect all 4 beats pushed; done pulse with axi_error=1; axi_error cleared at the next start.
- Protocol mismatch: burst_len=3 with rlast on beat 1. Expect burst end after 2 beats, axi_error=1, beat_count=2. Separately, rst=1 during DATA: next cycle arvalid=rready=rd_busy=0, and no done pulse.
- With DMA_RD_TIMEOUT_EN and TIMEOUT_CYCLES=8: rvalid held 0 after the AR handshake. Expect read_burst_done with axi_error=1 after 8 idle cycles.
